// File: rtl/tlul_reg_responder.sv
// TL-UL device-side responder: terminates one crossbar port, runs a single
// transaction at a time through a req/gnt/rvalid register backend and always
// answers on the D channel. Illegal requests and backend timeouts return d_error.

package tlul_pkg;

    // A-channel opcodes
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    // D-channel opcodes
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_reg_responder #(
    parameter int unsigned RegAw         = 8,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              req_o,
    output logic              we_o,
    output logic [RegAw-1:0]  addr_o,
    output logic [31:0]       wdata_o,
    output logic [3:0]        be_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [31:0]       rdata_i,
    input  logic              error_i
);
    import tlul_pkg::*;

    // A zero TimeoutCycles still needs a one-bit counter so the logic elaborates.
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    // The counter reads 0 in the first WAIT_RSP cycle, so the last waiting cycle is T-1.
    localparam logic [CntW-1:0] TimeoutLast =
        (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_e;

    state_e            state_q, state_d;
    logic              init_q;      // low for the first cycle after reset so a_ready rises late
    logic [2:0]        opcode_q;
    logic [1:0]        size_q;
    logic [7:0]        source_q;
    logic [RegAw-1:0]  addr_q;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              we_q;
    logic              err_q;
    logic [CntW-1:0]   cnt_q;

    logic              a_fire;
    logic              a_legal;
    logic              timeout_hit;
    logic              unused_bits;

    assign a_fire      = (state_q == IDLE) && init_q && tl_i.a_valid;
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);

    // Routing is resolved upstream, so upper address bits and a_param carry no meaning here.
    assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:RegAw]};

    // Protocol legality of the request currently on the A channel.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        a_legal = 1'b1;
        if ((tl_i.a_opcode != PutFullData) && (tl_i.a_opcode != PutPartialData) &&
            (tl_i.a_opcode != Get)) begin
            a_legal = 1'b0;
        end
        if (tl_i.a_size > 2'd2) begin
            a_legal = 1'b0;
        end
        if (tl_i.a_address[1:0] != 2'b00) begin
            a_legal = 1'b0;
        end
        if ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hF)) begin
            a_legal = 1'b0;
        end
    end

    // State register; a synchronous reset drops whatever transaction is in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    // Request capture, backend response capture and the saturating timeout counter.
    always_ff @(posedge clk_i) begin
        // NOTE: these are a handful of flops, not a memory array, so all are reset to give defined outputs.
        if (!rst_ni) begin
            opcode_q <= '0;
            size_q   <= '0;
            source_q <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (a_fire) begin
                opcode_q <= tl_i.a_opcode;
                size_q   <= tl_i.a_size;
                source_q <= tl_i.a_source;
                addr_q   <= tl_i.a_address[RegAw-1:0];
                mask_q   <= tl_i.a_mask;
                wdata_q  <= tl_i.a_data;
                rdata_q  <= '0;
                we_q     <= (tl_i.a_opcode != Get);
                err_q    <= !a_legal;
            end
            if ((state_q == REQ) && gnt_i) begin
                cnt_q <= '0;
            end
            if (state_q == WAIT_RSP) begin
                if (rvalid_i) begin
                    // A response on the timeout cycle still counts as a normal completion.
                    if (!we_q) begin
                        rdata_q <= rdata_i;
                    end
                    err_q <= error_i;
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Next-state logic for the single-outstanding transaction sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (a_fire) state_d = a_legal ? REQ : RESP;
            REQ:      if (gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: if (rvalid_i || timeout_hit) state_d = RESP;
            RESP:     if (tl_i.d_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // D-channel fields come only from captured registers, so they hold steady while stalled.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = (state_q == IDLE) && init_q;
        if (state_q == RESP) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = (opcode_q == Get) ? AccessAckData : AccessAck;
            tl_o.d_size   = size_q;
            tl_o.d_source = source_q;
            tl_o.d_error  = err_q;
            if (opcode_q == Get) begin
                tl_o.d_data = err_q ? 32'hFFFF_FFFF : rdata_q;
            end
        end
    end

    assign req_o   = (state_q == REQ);
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign be_o    = mask_q;

endmodule
